bus_arbiter_rr: RTL and testbench

Round-robin arbiter that shares the system bus between up to NUM_REQ masters, such as the JTAG DMA engine and the CPU. Each master drives request and waits for its one-hot grant line. Ownership is tracked by snooping begin/end/error on the shared bus, and the grant is released after each transaction. Sits in the system_clock domain, between master request/granted pins and the bus.

---
 rtl/bus_arbiter_rr.sv | 112 +++++++++++
 tb/tb_bus_arbiter_rr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin system bus arbiter; snoops begin/end/error to track ownership. Optional grant timeout under BUS_ARB_TIMEOUT_EN.
// Latency: request sampled at edge t gives grant after edge t; release to next grant takes one idle turnaround cycle.
// Backpressure: a granted master holds the bus until end/error (or withdrawal before begin); others wait on their request level.
module bus_arbiter_rr #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                system_clock,
  input  logic                system_reset,
  input  logic [NUM_REQ-1:0]  request,
  input  logic                begin_transactionIN,
  input  logic                end_transactionIN,
  input  logic                errorIN,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] active_id,
  output logic                bus_idle,
  output logic                timeout_pulse
);

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_last;
  logic                arb_found;
  logic [ID_WIDTH-1:0] arb_winner;
  logic [ID_WIDTH-1:0] cand;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Search starts just after the last winner so the previous owner goes to the back.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(rr_last) + i) % NUM_REQ);
      if (!arb_found && request[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      state     <= IDLE;
      grant     <= '0;
      active_id <= '0;
      bus_idle  <= 1'b1;
      rr_last   <= ID_WIDTH'(NUM_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE, RELEASE: begin
          if (arb_found) begin
            state     <= GRANTED;
            grant     <= NUM_REQ'(1) << arb_winner;
            active_id <= arb_winner;
            rr_last   <= arb_winner;
            bus_idle  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else begin
            state    <= IDLE;
            grant    <= '0;
            bus_idle <= 1'b1;
          end
        end
        GRANTED: begin
          if (begin_transactionIN) begin
            state <= BUSY;
          end else if (!request[active_id]) begin
            state <= RELEASE;
            grant <= '0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= RELEASE;
            grant         <= '0;
            timeout_pulse <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        BUSY: begin
          if (end_transactionIN || errorIN) begin
            state <= RELEASE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BUS_ARB_TIMEOUT_EN
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: directed scenarios plus random traffic against an ownership-level model.
module tb_bus_arbiter_rr;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int TMO = 16;

  logic           system_clock;
  logic           system_reset;
  logic [N-1:0]   request;
  logic           begin_transactionIN;
  logic           end_transactionIN;
  logic           errorIN;
  logic [N-1:0]   grant;
  logic [IDW-1:0] active_id;
  logic           bus_idle;
  logic           timeout_pulse;

  bus_arbiter_rr #(.NUM_REQ(N), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .system_clock        (system_clock),
    .system_reset        (system_reset),
    .request             (request),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .errorIN             (errorIN),
    .grant               (grant),
    .active_id           (active_id),
    .bus_idle            (bus_idle),
    .timeout_pulse       (timeout_pulse)
  );

  typedef struct {
    logic [N-1:0] grant;
    int           aid;
    logic         idle;
    logic         pulse;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: who owns the bus, whether its transaction has begun, and who won last.
  int owner;
  bit in_txn;
  int last;
  int waited;
  bit m_idle;
  int m_aid;
  bit m_pulse;

  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    owner = -1; in_txn = 0; last = N - 1; waited = 0;
    m_idle = 1; m_aid = 0; m_pulse = 0;
  endfunction

  function automatic void model_release();
    owner  = -1;
    in_txn = 0;
    m_idle = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input bit b, input bit e, input bit err);
    int best, bestd, d;
    m_pulse = 0;
    if (owner < 0) begin
      if (req != '0) begin
        best = -1; bestd = N;
        for (int m = 0; m < N; m++) begin
          d = (m - last - 1 + 2 * N) % N;
          if (req[m] && d < bestd) begin best = m; bestd = d; end
        end
        owner = best; last = best; m_aid = best;
        in_txn = 0; waited = 0; m_idle = 0;
      end else begin
        m_idle = 1;
      end
    end else if (!in_txn) begin
      if (b) in_txn = 1;
      else if (!req[owner]) model_release();
      else begin
        waited++;
`ifdef BUS_ARB_TIMEOUT_EN
        if (waited >= TMO) begin model_release(); m_pulse = 1; end
`endif
      end
    end else if (e || err) begin
      model_release();
    end
  endfunction

  function automatic void push_exp();
    exp_t x;
    x.grant = (owner < 0) ? '0 : N'(1 << owner);
    x.aid   = m_aid;
    x.idle  = m_idle;
    x.pulse = m_pulse;
    exp_q.push_back(x);
  endfunction

  // Monitor: registered outputs are sampled on the falling edge after each scored rising edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge system_clock);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("grant", int'(grant), int'(x.grant));
        check("bus_idle", int'(bus_idle), int'(x.idle));
        check("timeout_pulse", int'(timeout_pulse), int'(x.pulse));
        check("grant_onehot", int'($countones(grant) <= 1), 1);
        if (x.grant != '0) check("active_id", int'(active_id), x.aid);
      end
    end
  end

  task automatic cycle(input logic [N-1:0] req, input bit b, input bit e, input bit err);
    request             = req;
    begin_transactionIN = b;
    end_transactionIN   = e;
    errorIN             = err;
    @(posedge system_clock);
    model_step(req, b, e, err);
    push_exp();
    @(negedge system_clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    system_reset        = 1'b1;
    request             = '0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    errorIN             = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge system_clock);
      model_reset();
      push_exp();
      @(negedge system_clock);
      #1;
    end
    system_reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rq;
    model_reset();
    do_reset(2);

    // First arbitration from reset skips nothing: 0110 gives master 1, then master 2 after turnaround.
    cycle(4'b0110, 0, 0, 0);
    check("first_grant", int'(grant), 'b0010);
    check("first_active_id", int'(active_id), 1);
    cycle(4'b0110, 1, 0, 0);
    cycle(4'b0110, 0, 1, 0);
    check("turnaround_gap", int'(grant), 0);
    cycle(4'b0110, 0, 0, 0);
    check("second_grant", int'(grant), 'b0100);
    cycle(4'b0100, 1, 0, 0);
    cycle(4'b0100, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0);

    // All masters requesting: rotation 0,1,2,3,0.
    do_reset(1);
    cycle(4'b1111, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check("rotation", int'(grant), 1 << (k % N));
      cycle(4'b1111, 1, 0, 0);
      cycle(4'b1111, 0, 1, 0);
      cycle(4'b1111, 0, 0, 0);
    end

    // Withdrawal before begin, then begin racing a request drop.
    do_reset(1);
    cycle(4'b0100, 0, 0, 0);
    check("withdraw_granted", int'(grant), 'b0100);
    cycle(4'b0000, 0, 0, 0);
    check("withdraw_release", int'(grant), 0);
    check("withdraw_not_idle", int'(bus_idle), 0);
    cycle(4'b0000, 0, 0, 0);
    check("withdraw_idle", int'(bus_idle), 1);
    cycle(4'b0100, 0, 0, 0);
    cycle(4'b0000, 1, 0, 0);
    check("begin_wins_drop", int'(grant), 'b0100);
    cycle(4'b0000, 0, 0, 0);
    check("busy_holds_grant", int'(grant), 'b0100);
    cycle(4'b0000, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0);

    // Master 1 busy: drop ignored, end+error together release once.
    cycle(4'b0010, 0, 0, 0);
    cycle(4'b0010, 1, 0, 0);
    cycle(4'b0000, 0, 0, 0);
    check("drop_in_busy", int'(grant), 'b0010);
    cycle(4'b0000, 1, 0, 0);
    check("second_begin_ignored", int'(grant), 'b0010);
    cycle(4'b0000, 0, 1, 1);
    check("end_err_release", int'(grant), 0);
    cycle(4'b0000, 0, 0, 0);
    check("end_err_idle", int'(bus_idle), 1);

`ifdef BUS_ARB_TIMEOUT_EN
    do_reset(1);
    cycle(4'b0011, 0, 0, 0);
    for (int k = 0; k < TMO - 1; k++) cycle(4'b0011, 0, 0, 0);
    check("tmo_still_granted", int'(grant), 'b0001);
    cycle(4'b0011, 0, 0, 0);
    check("tmo_grant_drop", int'(grant), 0);
    check("tmo_pulse", int'(timeout_pulse), 1);
    cycle(4'b0011, 0, 0, 0);
    check("tmo_next_master", int'(grant), 'b0010);
    check("tmo_pulse_once", int'(timeout_pulse), 0);
`endif

    // Asynchronous reset while BUSY, then rr pointer restarts.
    do_reset(1);
    cycle(4'b0001, 0, 0, 0);
    cycle(4'b0001, 1, 0, 0);
    system_reset = 1'b1;
    #1;
    check("async_reset_grant", int'(grant), 0);
    check("async_reset_idle", int'(bus_idle), 1);
    do_reset(2);
    cycle(4'b1000, 0, 0, 0);
    check("post_reset_m3", int'(grant), 'b1000);
    cycle(4'b1111, 1, 0, 0);
    cycle(4'b1111, 0, 1, 0);
    cycle(4'b1111, 0, 0, 0);
    check("after_m3_m0", int'(grant), 'b0001);

    // Random traffic against the model.
    rq = 4'b0101;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      cycle(rq, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    cycle(4'b0000, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
